l1_trigger_rate_scaler: RTL and testbench
=========================================

// Module: l1_trigger_rate_scaler
// PURPOSE
//  Parametrised per-beam trigger qualifier and rate scaler for the L1 beamformed trigger path.
//  Sits after beamform_trigger. Applies a runtime-programmable per-beam holdoff and mask to the raw beam bits.
//  Counts qualified triggers over a programmable window, in single-shot or continuous (back-to-back, no dead time) mode.
//  Results are double-buffered, saturating, and readable by beam index. Single clock domain; the CSR bridge lives outside.
// PARAMETERS
//  NBEAMS        2    number of beams
//  COUNT_BITS    32   width of each per-beam trigger counter
//  PERIOD_BITS   32   width of window length (aclk cycles)
//  HOLDOFF_BITS  8    width of per-trigger holdoff (aclk cycles)
//  IDX_BITS      8    width of readout beam index
// PORTS
//  aclk           in   1             clock (one clock; all I/O synchronous to it)
//  reset_i        in   1             synchronous, active-high reset
//  trig_i         in   NBEAMS        raw beam trigger bits
//  beam_mask_i    in   NBEAMS        1 = beam disabled
//  holdoff_i      in   HOLDOFF_BITS  cycles of holdoff after each qualified trigger
//  period_i       in   PERIOD_BITS   window length in cycles; 0 treated as 1
//  continuous_i   in   1             1 = auto-restart window; 0 = single-shot
//  start_i        in   1             pulse: begin/restart window
//  stop_i         in   1             pulse: abort counting
//  rd_idx_i       in   IDX_BITS      beam index to read
//  rd_dat_o       out  COUNT_BITS+1  {overflow, count} of latched result, rd_idx_i
//  trigger_o      out  NBEAMS        qualified trigger, registered
//  busy_o         out  1             state == COUNT
//  done_o         out  1             1-cycle pulse: new results latched
//  window_cnt_o   out  16            completed windows since reset, wraps
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, live/result counters, overflow bits, holdoff counters and window_cnt_o all cleared.
//  Qualify per beam b:
//   hit[b] = trig_i[b] & ~beam_mask_i[b] & (hold[b]==0).
//   On hit, hold[b] <= holdoff_i; else if hold[b]!=0, hold[b]--.
//   trigger_o[b] <= hit[b]: 1-cycle latency. Holdoff runs in every state.
//   holdoff_i==0 -> consecutive high cycles all qualify.
//   A masked beam never starts holdoff; an in-progress holdoff still counts down.
//  FSM, IDLE and COUNT:
//   IDLE + start_i: live<=0, ovf_live<=0, timer<=max(period_i,1), go to COUNT. The next cycle is window cycle 1.
//   COUNT, each cycle: live[b] += hit[b], saturating at 2^COUNT_BITS-1; a hit while saturated sets ovf_live[b]. Then timer--.
//   COUNT with timer==1 (last cycle): result[b] <= live[b]+hit[b] (saturated); ovf_res <= ovf_live | new overflow.
//    done_o=1 on the next cycle; window_cnt_o++.
//    If continuous_i: live<=0, timer<=max(period_i,1), stay in COUNT, so there is no dead cycle.
//    Otherwise return to IDLE.
//   period_i and continuous_i are sampled only at start and at reload.
//   stop_i in COUNT: go to IDLE. Results, done_o and window_cnt_o are unchanged; live counts are discarded.
//   start_i in COUNT without stop_i: restart the window (clear live, reload timer); results unchanged.
//   start_i and stop_i together: stop wins.
//   stop_i in IDLE: ignored.
//   reset_i mid-window: immediate return to reset state, no done_o.
//  Readout: rd_dat_o <= {ovf_res[idx], result[idx]}, 1-cycle latency.
//   idx >= NBEAMS returns 0.
//   The result bank only changes on the latch cycle, so a read in the done_o cycle returns the new value.
//  Counts cover exactly period_i cycles of hits; hits in IDLE drive trigger_o but are not counted.
// TESTING
//  T1: holdoff_i=4, trig_i[0] held high 20 cycles -> trigger_o[0] pulses every 5 cycles, 4 pulses total, 1 cycle after the qualifying edge.
//  T2: period_i=100, single-shot, trig_i[1] toggling every cycle, holdoff 0 -> done_o once, 101 cycles after start_i. rd_idx_i=1 -> count 50, ovf 0. busy_o low afterward.
//  T3: continuous, period_i=10, constant trig_i, holdoff 0 -> done_o every 10 cycles. Each result = 10 with no lost cycles. window_cnt_o increments to 5 after 50 cycles.
//  T4: COUNT_BITS=4, 20 hits in a window -> count 15, ovf 1. The next window with 3 hits -> count 3, ovf 0.
//  T5: stop_i at window cycle 50 of 100 -> no done_o, previous results retained. start_i+stop_i together -> remains IDLE. period_i=0 -> 1-cycle windows.
//  T6: beam_mask_i[0]=1 -> trigger_o[0]=0 and count 0. reset_i mid-window -> all outputs 0 the next cycle; rd_idx_i=NBEAMS -> rd_dat_o=0.

Source files
------------

// File: rtl/l1_trigger_rate_scaler.sv
// l1_trigger_rate_scaler
//   Per-beam trigger qualifier and rate scaler for the L1 beamformed trigger
//   path. Each raw beam bit goes through a mask and a programmable holdoff.
//   The qualified hits are counted over a programmable window, either once
//   (single-shot) or back to back (continuous). Window results are latched
//   into a saturating result bank that can be read by beam index.
//
// Ports
//   aclk          clock; all I/O is synchronous to it
//   reset_i       synchronous, active-high reset
//   trig_i        raw beam trigger bits
//   beam_mask_i   1 = beam disabled
//   holdoff_i     holdoff cycles after each qualified trigger
//   period_i      window length in cycles (0 is treated as 1)
//   continuous_i  1 = restart the window automatically
//   start_i       pulse: begin or restart a window
//   stop_i        pulse: abort counting (wins over start_i)
//   rd_idx_i      beam index to read
//   rd_dat_o      {overflow, count} of the latched result, 1-cycle latency
//   trigger_o     qualified trigger bits, registered
//   busy_o        high while a window is being counted
//   done_o        1-cycle pulse when new results have been latched
//   window_cnt_o  completed windows since reset (wraps)
module l1_trigger_rate_scaler #(
  parameter int NBEAMS       = 2,
  parameter int COUNT_BITS   = 32,
  parameter int PERIOD_BITS  = 32,
  parameter int HOLDOFF_BITS = 8,
  parameter int IDX_BITS     = 8
) (
  input  logic                    aclk,
  input  logic                    reset_i,
  input  logic [NBEAMS-1:0]       trig_i,
  input  logic [NBEAMS-1:0]       beam_mask_i,
  input  logic [HOLDOFF_BITS-1:0] holdoff_i,
  input  logic [PERIOD_BITS-1:0]  period_i,
  input  logic                    continuous_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [IDX_BITS-1:0]     rd_idx_i,
  output logic [COUNT_BITS:0]     rd_dat_o,
  output logic [NBEAMS-1:0]       trigger_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [15:0]             window_cnt_o
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_COUNT = 1'b1;

  localparam logic [COUNT_BITS-1:0]  COUNT_MAX  = '1;
  localparam logic [PERIOD_BITS-1:0] PERIOD_ONE = PERIOD_BITS'(1);

  logic                    state;
  logic                    cont_r;
  logic [PERIOD_BITS-1:0]  timer;
  logic [PERIOD_BITS-1:0]  period_eff;

  logic [HOLDOFF_BITS-1:0] hold     [NBEAMS];
  logic [COUNT_BITS-1:0]   live     [NBEAMS];
  logic [COUNT_BITS-1:0]   result   [NBEAMS];
  logic [NBEAMS-1:0]       ovf_live;
  logic [NBEAMS-1:0]       ovf_res;

  logic [NBEAMS-1:0]       hit;
  logic [COUNT_BITS-1:0]   live_next [NBEAMS];
  logic [NBEAMS-1:0]       sat_hit;
  logic [COUNT_BITS:0]     rd_next;

  assign period_eff = (period_i == '0) ? PERIOD_ONE : period_i;
  assign busy_o     = (state == ST_COUNT);

  // Qualification and saturating increment of the live counters.
  always_comb begin
    hit     = '0;
    sat_hit = '0;
    for (int unsigned b = 0; b < NBEAMS; b++) begin
      hit[b]       = trig_i[b] & ~beam_mask_i[b] & (hold[b] == '0);
      live_next[b] = live[b];
      if (hit[b]) begin
        if (live[b] == COUNT_MAX) begin
          sat_hit[b] = 1'b1;
        end else begin
          live_next[b] = live[b] + COUNT_BITS'(1);
        end
      end
    end
  end

  // Readout mux; indices outside the beam range read as zero.
  always_comb begin
    rd_next = '0;
    for (int unsigned b = 0; b < NBEAMS; b++) begin
      if (rd_idx_i == IDX_BITS'(b)) begin
        rd_next = {ovf_res[b], result[b]};
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (reset_i) begin
      state        <= ST_IDLE;
      cont_r       <= 1'b0;
      timer        <= '0;
      ovf_live     <= '0;
      ovf_res      <= '0;
      rd_dat_o     <= '0;
      trigger_o    <= '0;
      done_o       <= 1'b0;
      window_cnt_o <= '0;
      for (int unsigned b = 0; b < NBEAMS; b++) begin
        hold[b]   <= '0;
        live[b]   <= '0;
        result[b] <= '0;
      end
    end else begin
      done_o    <= 1'b0;
      trigger_o <= hit;
      rd_dat_o  <= rd_next;

      // Holdoff runs independently of the counting state.
      for (int unsigned b = 0; b < NBEAMS; b++) begin
        if (hit[b]) begin
          hold[b] <= holdoff_i;
        end else if (hold[b] != '0) begin
          hold[b] <= hold[b] - HOLDOFF_BITS'(1);
        end
      end

      case (state)
        ST_IDLE: begin
          if (start_i && !stop_i) begin
            state    <= ST_COUNT;
            timer    <= period_eff;
            cont_r   <= continuous_i;
            ovf_live <= '0;
            for (int unsigned b = 0; b < NBEAMS; b++) begin
              live[b] <= '0;
            end
          end
        end

        ST_COUNT: begin
          if (stop_i) begin
            state <= ST_IDLE;
          end else if (start_i) begin
            timer    <= period_eff;
            cont_r   <= continuous_i;
            ovf_live <= '0;
            for (int unsigned b = 0; b < NBEAMS; b++) begin
              live[b] <= '0;
            end
          end else if (timer == PERIOD_ONE) begin
            // Last window cycle: this cycle's hits are folded straight into
            // the result so a continuous reload loses nothing.
            ovf_res      <= ovf_live | sat_hit;
            done_o       <= 1'b1;
            window_cnt_o <= window_cnt_o + 16'd1;
            ovf_live     <= '0;
            for (int unsigned b = 0; b < NBEAMS; b++) begin
              result[b] <= live_next[b];
              live[b]   <= '0;
            end
            if (cont_r) begin
              timer  <= period_eff;
              cont_r <= continuous_i;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            timer    <= timer - PERIOD_ONE;
            ovf_live <= ovf_live | sat_hit;
            for (int unsigned b = 0; b < NBEAMS; b++) begin
              live[b] <= live_next[b];
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_trigger_rate_scaler.sv
// Directed testbench for l1_trigger_rate_scaler. A default-width instance and
// a 4-bit-counter instance share all inputs; the narrow one is only checked
// for the saturation test.
module tb_l1_trigger_rate_scaler;

  localparam int NBEAMS       = 2;
  localparam int COUNT_BITS   = 32;
  localparam int PERIOD_BITS  = 32;
  localparam int HOLDOFF_BITS = 8;
  localparam int IDX_BITS     = 8;

  logic                    aclk = 1'b0;
  logic                    reset_i;
  logic [NBEAMS-1:0]       trig_i;
  logic [NBEAMS-1:0]       beam_mask_i;
  logic [HOLDOFF_BITS-1:0] holdoff_i;
  logic [PERIOD_BITS-1:0]  period_i;
  logic                    continuous_i;
  logic                    start_i;
  logic                    stop_i;
  logic [IDX_BITS-1:0]     rd_idx_i;

  logic [COUNT_BITS:0]     rd_dat;
  logic [NBEAMS-1:0]       trigger;
  logic                    busy;
  logic                    done;
  logic [15:0]             window_cnt;

  logic [4:0]              rd_dat4;
  logic [NBEAMS-1:0]       trigger4;
  logic                    busy4;
  logic                    done4;
  logic [15:0]             window_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  l1_trigger_rate_scaler #(
    .NBEAMS(NBEAMS), .COUNT_BITS(COUNT_BITS), .PERIOD_BITS(PERIOD_BITS),
    .HOLDOFF_BITS(HOLDOFF_BITS), .IDX_BITS(IDX_BITS)
  ) dut (
    .aclk(aclk), .reset_i(reset_i), .trig_i(trig_i), .beam_mask_i(beam_mask_i),
    .holdoff_i(holdoff_i), .period_i(period_i), .continuous_i(continuous_i),
    .start_i(start_i), .stop_i(stop_i), .rd_idx_i(rd_idx_i),
    .rd_dat_o(rd_dat), .trigger_o(trigger), .busy_o(busy), .done_o(done),
    .window_cnt_o(window_cnt)
  );

  l1_trigger_rate_scaler #(
    .NBEAMS(NBEAMS), .COUNT_BITS(4), .PERIOD_BITS(PERIOD_BITS),
    .HOLDOFF_BITS(HOLDOFF_BITS), .IDX_BITS(IDX_BITS)
  ) dut4 (
    .aclk(aclk), .reset_i(reset_i), .trig_i(trig_i), .beam_mask_i(beam_mask_i),
    .holdoff_i(holdoff_i), .period_i(period_i), .continuous_i(continuous_i),
    .start_i(start_i), .stop_i(stop_i), .rd_idx_i(rd_idx_i),
    .rd_dat_o(rd_dat4), .trigger_o(trigger4), .busy_o(busy4), .done_o(done4),
    .window_cnt_o(window_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int pulses;

    reset_i      = 1'b1;
    trig_i       = '0;
    beam_mask_i  = '0;
    holdoff_i    = '0;
    period_i     = '0;
    continuous_i = 1'b0;
    start_i      = 1'b0;
    stop_i       = 1'b0;
    rd_idx_i     = '0;
    repeat (3) tick();

    chk("rst_trigger", 64'(trigger), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_window_cnt", 64'(window_cnt), 64'd0);
    chk("rst_rd_dat", 64'(rd_dat), 64'd0);
    reset_i = 1'b0;
    tick();

    // T1: holdoff 4, beam 0 held high for 20 cycles -> pulse every 5th cycle.
    holdoff_i = 8'd4;
    trig_i    = 2'b01;
    pulses    = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t1_trigger0", 64'(trigger[0]), (i % 5 == 0) ? 64'd1 : 64'd0);
      if (trigger[0]) pulses++;
    end
    chk("t1_pulses", 64'(pulses), 64'd4);
    chk("t1_trigger1", 64'(trigger[1]), 64'd0);
    trig_i    = '0;
    holdoff_i = '0;
    tick();
    chk("t1_trigger_off", 64'(trigger), 64'd0);

    // T2: single-shot 100-cycle window, beam 1 toggling -> 50 hits.
    period_i     = 32'd100;
    continuous_i = 1'b0;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t2_busy", 64'(busy), 64'd1);
    pulses = 0;
    for (int k = 1; k <= 100; k++) begin
      trig_i = {1'(k % 2), 1'b0};
      tick();
      if (done) pulses++;
    end
    chk("t2_done_at_101", 64'(done), 64'd1);
    chk("t2_done_once", 64'(pulses), 64'd1);
    chk("t2_busy_after", 64'(busy), 64'd0);
    chk("t2_window_cnt", 64'(window_cnt), 64'd1);
    trig_i   = '0;
    rd_idx_i = 8'd1;
    tick();
    chk("t2_rd_beam1", 64'(rd_dat), 64'd50);
    chk("t2_done_low", 64'(done), 64'd0);
    rd_idx_i = 8'd0;
    tick();
    chk("t2_rd_beam0", 64'(rd_dat), 64'd0);

    // T3: continuous 10-cycle windows with both beams always high.
    reset_i = 1'b1;
    tick();
    reset_i      = 1'b0;
    period_i     = 32'd10;
    continuous_i = 1'b1;
    trig_i       = 2'b11;
    rd_idx_i     = 8'd0;
    start_i      = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("t3_done", 64'(done), (k % 10 == 0) ? 64'd1 : 64'd0);
      if (k > 10 && k % 10 == 1) chk("t3_rd_count", 64'(rd_dat), 64'd10);
    end
    chk("t3_window_cnt", 64'(window_cnt), 64'd5);
    chk("t3_busy", 64'(busy), 64'd1);
    stop_i       = 1'b1;
    continuous_i = 1'b0;
    tick();
    stop_i = 1'b0;
    chk("t3_stop_busy", 64'(busy), 64'd0);
    chk("t3_stop_done", 64'(done), 64'd0);
    chk("t3_stop_window_cnt", 64'(window_cnt), 64'd5);

    // T4: 20 hits into a 4-bit counter saturate; next 3-hit window is clean.
    period_i = 32'd20;
    trig_i   = 2'b01;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (20) tick();
    chk("t4_done", 64'(done4), 64'd1);
    tick();
    chk("t4_sat_rd", 64'(rd_dat4), 64'h1F);
    chk("t4_wide_rd", 64'(rd_dat), 64'd20);
    period_i = 32'd3;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    chk("t4_done2", 64'(done4), 64'd1);
    tick();
    chk("t4_clean_rd", 64'(rd_dat4), 64'h03);
    chk("t4_wide_rd2", 64'(rd_dat), 64'd3);
    chk("t4_window_cnt", 64'(window_cnt), 64'd7);

    // T5: stop mid-window, start+stop together, zero period.
    period_i = 32'd100;
    trig_i   = 2'b11;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (49) tick();
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("t5_stop_busy", 64'(busy), 64'd0);
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done) pulses++;
    end
    chk("t5_no_done", 64'(pulses), 64'd0);
    chk("t5_result_kept", 64'(rd_dat), 64'd3);
    chk("t5_window_cnt", 64'(window_cnt), 64'd7);
    start_i = 1'b1;
    stop_i  = 1'b1;
    tick();
    start_i = 1'b0;
    stop_i  = 1'b0;
    chk("t5_start_stop_idle", 64'(busy), 64'd0);
    tick();
    chk("t5_still_idle", 64'(busy), 64'd0);
    period_i = 32'd0;
    start_i  = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t5_p0_busy", 64'(busy), 64'd1);
    tick();
    chk("t5_p0_done", 64'(done), 64'd1);
    chk("t5_p0_idle", 64'(busy), 64'd0);
    chk("t5_p0_window_cnt", 64'(window_cnt), 64'd8);
    tick();
    chk("t5_p0_rd", 64'(rd_dat), 64'd1);
    chk("t5_p0_done_low", 64'(done), 64'd0);

    // T6: beam 0 masked, out-of-range read, reset mid-window.
    beam_mask_i = 2'b01;
    period_i    = 32'd5;
    trig_i      = 2'b11;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    chk("t6_masked_trigger", 64'(trigger), 64'h2);
    repeat (5) tick();
    chk("t6_done", 64'(done), 64'd1);
    rd_idx_i = 8'd0;
    tick();
    chk("t6_rd_masked", 64'(rd_dat), 64'd0);
    rd_idx_i = 8'd1;
    tick();
    chk("t6_rd_beam1", 64'(rd_dat), 64'd5);
    rd_idx_i = 8'(NBEAMS);
    tick();
    chk("t6_rd_out_of_range", 64'(rd_dat), 64'd0);
    rd_idx_i    = 8'd1;
    beam_mask_i = '0;
    period_i    = 32'd100;
    start_i     = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (10) tick();
    chk("t6_pre_reset_rd", 64'(rd_dat), 64'd5);
    reset_i = 1'b1;
    tick();
    chk("t6_rst_trigger", 64'(trigger), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_window_cnt", 64'(window_cnt), 64'd0);
    chk("t6_rst_rd", 64'(rd_dat), 64'd0);
    reset_i = 1'b0;
    trig_i  = '0;
    tick();
    chk("t6_post_rst_done", 64'(done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
